// File: rtl/gabor_pkg.sv
// Shared constants, state type and address helper for the pixel window fetch.
// Contents:
//   ADDR_W/ROW_STRIDE/WIN/PIX_W/OUT_W/MEM_LAT  geometry and RAM timing
//   NPIX                                       pixels per window
//   fetch_state_t                              fetch FSM states
//   win_offset(r, c)                           address offset of window pixel (r, c)
package gabor_pkg;

    localparam int unsigned ADDR_W     = 19;
    localparam int unsigned ROW_STRIDE = 516;
    localparam int unsigned WIN        = 5;
    localparam int unsigned PIX_W      = 8;
    localparam int unsigned OUT_W      = 10;
    localparam int unsigned MEM_LAT    = 1;
    localparam int unsigned NPIX       = WIN * WIN;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DRAIN   = 2'd2,
        PRESENT = 2'd3
    } fetch_state_t;

    // Offset is truncated to ADDR_W so that base + offset wraps silently.
    function automatic logic [ADDR_W-1:0] win_offset(input logic [2:0] r, input logic [2:0] c);
        return ADDR_W'(r) * ADDR_W'(ROW_STRIDE) + ADDR_W'(c);
    endfunction

endpackage

// File: rtl/window_shift_reg.sv
// WIN x WIN pixel store with a single write port and a column-shift-left strobe.
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset, clears every pixel
//   shift_en  move every column one place left (column 0 is discarded)
//   wr_en     write wr_data into slot (wr_row, wr_col); applied after the shift
//   wr_row    row index 0..WIN-1
//   wr_col    column index 0..WIN-1
//   wr_data   pixel byte
//   pixels    flat row-major window, slot k at [(k+1)*OUT_W-1 -: OUT_W], zero-extended
module window_shift_reg
    import gabor_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    shift_en,
    input  logic                    wr_en,
    input  logic [2:0]              wr_row,
    input  logic [2:0]              wr_col,
    input  logic [PIX_W-1:0]        wr_data,
    output logic [NPIX*OUT_W-1:0]   pixels
);

    logic [PIX_W-1:0] win_q [NPIX];
    logic [PIX_W-1:0] win_d [NPIX];
    logic [4:0]       wr_idx;

    assign wr_idx = 5'(wr_row) * 5'(WIN) + 5'(wr_col);

    always_comb begin
        win_d = win_q;
        if (shift_en) begin
            for (int unsigned r = 0; r < WIN; r++) begin
                for (int unsigned c = 0; c < WIN - 1; c++) begin
                    win_d[r*WIN + c] = win_q[r*WIN + c + 1];
                end
            end
        end
        if (wr_en) begin
            win_d[wr_idx] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_q <= '{default: '0};
        end else begin
            win_q <= win_d;
        end
    end

    always_comb begin
        pixels = '0;
        for (int unsigned k = 0; k < NPIX; k++) begin
            pixels[k*OUT_W +: OUT_W] = {{(OUT_W-PIX_W){1'b0}}, win_q[k]};
        end
    end

endmodule

// File: rtl/pixel_window_fetch.sv
// Fetches a 5x5 pixel window from a single-port synchronous image RAM.
// A request whose base is one pixel right of the previously presented window
// reuses 20 pixels and reads only the new right-hand column.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   flush      invalidate the reuse cache (honoured in IDLE only)
//   req_valid  window request valid
//   req_addr   window base address (top-left pixel)
//   req_ready  high in IDLE; request accepted on req_valid && req_ready
//   mem_en     RAM read strobe
//   mem_addr   RAM read address
//   mem_rdata  RAM read data, MEM_LAT cycles after mem_en
//   win_valid  window valid (held until win_ready)
//   win_ready  consumer accepts window
//   pixels     row-major window, pixelk at [k*OUT_W-1 -: OUT_W], k=1..25
module pixel_window_fetch
    import gabor_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    req_valid,
    input  logic [ADDR_W-1:0]       req_addr,
    output logic                    req_ready,
    output logic                    mem_en,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic [PIX_W-1:0]        mem_rdata,
    output logic                    win_valid,
    input  logic                    win_ready,
    output logic [NPIX*OUT_W-1:0]   pixels
);

    localparam int unsigned DRAIN_W = $clog2(MEM_LAT + 1);
    localparam logic [2:0]  LAST    = 3'(WIN - 1);

    fetch_state_t         state_q, state_d;
    logic [ADDR_W-1:0]    base_q, base_d;
    logic [ADDR_W-1:0]    last_addr_q, last_addr_d;
    logic                 slide_q, slide_d;
    logic                 reuse_q, reuse_d;
    logic [2:0]           row_q, row_d;
    logic [2:0]           col_q, col_d;
    logic [DRAIN_W-1:0]   drain_q, drain_d;
    logic [MEM_LAT-1:0]   pipe_vld_q, pipe_vld_d;
    logic [2:0]           pipe_row_q [MEM_LAT];
    logic [2:0]           pipe_row_d [MEM_LAT];
    logic [2:0]           pipe_col_q [MEM_LAT];
    logic [2:0]           pipe_col_d [MEM_LAT];
    logic                 shift_en;
    logic                 slide_hit;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        last_addr_d = last_addr_q;
        slide_d     = slide_q;
        reuse_d     = reuse_q;
        row_d       = row_q;
        col_d       = col_q;
        drain_d     = drain_q;
        shift_en    = 1'b0;
        slide_hit   = 1'b0;

        case (state_q)
            IDLE: begin
                if (flush) begin
                    reuse_d = 1'b0;
                end
                if (req_valid) begin
                    // flush in the same cycle forces a full fetch
                    slide_hit = reuse_q && !flush && (req_addr == last_addr_q + ADDR_W'(1));
                    base_d    = req_addr;
                    slide_d   = slide_hit;
                    // the left shift is applied on the accepting edge so column 4 is free
                    // before the first slide read returns
                    shift_en  = slide_hit;
                    row_d     = '0;
                    col_d     = slide_hit ? LAST : '0;
                    state_d   = FETCH;
                end
            end
            FETCH: begin
                // both fetch modes finish on slot (4,4)
                if (row_q == LAST && col_q == LAST) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else if (slide_q || col_q == LAST) begin
                    row_d = row_q + 3'd1;
                    col_d = slide_q ? LAST : '0;
                end else begin
                    col_d = col_q + 3'd1;
                end
            end
            DRAIN: begin
                // the last write lands on the first DRAIN edge; present one edge later
                if (drain_q == DRAIN_W'(MEM_LAT)) begin
                    state_d = PRESENT;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            PRESENT: begin
                if (win_ready) begin
                    state_d     = IDLE;
                    last_addr_d = base_q;
                    reuse_d     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Slot index travels alongside the read so returning data lands in its issue slot.
    always_comb begin
        pipe_vld_d    = pipe_vld_q;
        pipe_row_d    = pipe_row_q;
        pipe_col_d    = pipe_col_q;
        pipe_vld_d[0] = (state_q == FETCH);
        pipe_row_d[0] = row_q;
        pipe_col_d[0] = col_q;
        for (int unsigned i = 1; i < MEM_LAT; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_row_d[i] = pipe_row_q[i-1];
            pipe_col_d[i] = pipe_col_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            last_addr_q <= '0;
            slide_q     <= 1'b0;
            reuse_q     <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            drain_q     <= '0;
            pipe_vld_q  <= '0;
            pipe_row_q  <= '{default: '0};
            pipe_col_q  <= '{default: '0};
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            last_addr_q <= last_addr_d;
            slide_q     <= slide_d;
            reuse_q     <= reuse_d;
            row_q       <= row_d;
            col_q       <= col_d;
            drain_q     <= drain_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_row_q  <= pipe_row_d;
            pipe_col_q  <= pipe_col_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign win_valid = (state_q == PRESENT);
    assign mem_en    = (state_q == FETCH);
    assign mem_addr  = base_q + win_offset(row_q, col_q);

    window_shift_reg u_win (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .wr_en    (pipe_vld_q[MEM_LAT-1]),
        .wr_row   (pipe_row_q[MEM_LAT-1]),
        .wr_col   (pipe_col_q[MEM_LAT-1]),
        .wr_data  (mem_rdata),
        .pixels   (pixels)
    );

endmodule

// File: tb/tb_pixel_window_fetch.sv
// Self-checking bench for pixel_window_fetch with a 1-cycle RAM model mem[a] = a[7:0].
module tb_pixel_window_fetch;
    import gabor_pkg::*;

    localparam int unsigned PW = NPIX * OUT_W;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                flush = 1'b0;
    logic                req_valid = 1'b0;
    logic [ADDR_W-1:0]   req_addr = '0;
    logic                req_ready;
    logic                mem_en;
    logic [ADDR_W-1:0]   mem_addr;
    logic [PIX_W-1:0]    mem_rdata = '0;
    logic                win_valid;
    logic                win_ready = 1'b0;
    logic [PW-1:0]       pixels;

    int unsigned n_pass = 0;
    int unsigned n_chk  = 0;
    int unsigned reads  = 0;

    logic [ADDR_W-1:0] exp_addr_q [$];
    logic [PW-1:0]     exp_win_q  [$];
    bit                m_reuse = 1'b0;
    logic [ADDR_W-1:0] m_last  = '0;

    pixel_window_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .pixels    (pixels)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en === 1'b1) mem_rdata <= mem_addr[7:0];
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [PW-1:0] model_win(input logic [ADDR_W-1:0] b);
        logic [PW-1:0]     w;
        logic [ADDR_W-1:0] ad;
        w = '0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                ad = b + 19'(r * 516 + c);
                w[(r*5 + c)*10 +: 10] = {2'b00, ad[7:0]};
            end
        end
        return w;
    endfunction

    // One clock, then observe just after the edge; every read is scored in issue order.
    task automatic step();
        logic [ADDR_W-1:0] ea;
        @(posedge clk);
        #1;
        if (mem_en === 1'b1) begin
            reads++;
            if (exp_addr_q.size() > 0) begin
                ea = exp_addr_q.pop_front();
                check("mem_addr", mem_addr, ea);
            end
        end
    endtask

    task automatic run_req(input logic [ADDR_W-1:0] a, input bit fl, input int unsigned hold);
        bit            slide;
        int unsigned   n;
        int unsigned   lat;
        logic [PW-1:0] snap;
        logic [PW-1:0] ew;
        bit            stable;
        slide = m_reuse && !fl && (a == m_last + 19'd1);
        n = slide ? 5 : 25;
        for (int r = 0; r < 5; r++) begin
            for (int c = (slide ? 4 : 0); c < 5; c++) begin
                exp_addr_q.push_back(a + 19'(r * 516 + c));
            end
        end
        exp_win_q.push_back(model_win(a));
        req_addr  = a;
        req_valid = 1'b1;
        flush     = fl;
        reads     = 0;
        step();
        req_valid = 1'b0;
        flush     = 1'b0;
        lat = 0;
        while (win_valid !== 1'b1 && lat < 200) begin
            step();
            lat++;
        end
        check("latency", lat, n + 2);
        check("read_count", reads, n);
        check("reads_left", exp_addr_q.size(), 0);
        if (hold > 0) begin
            snap      = pixels;
            stable    = 1'b1;
            reads     = 0;
            req_valid = 1'b1;
            req_addr  = a + 19'd7;
            flush     = 1'b1;
            repeat (hold) begin
                step();
                if (pixels !== snap || win_valid !== 1'b1 || req_ready !== 1'b0) stable = 1'b0;
            end
            req_valid = 1'b0;
            flush     = 1'b0;
            check("bp_stable", stable, 1);
            check("bp_no_reads", reads, 0);
        end
        ew = exp_win_q.pop_front();
        check("window", pixels, ew);
        win_ready = 1'b1;
        step();
        win_ready = 1'b0;
        check("ready_after_hs", req_ready, 1);
        check("valid_after_hs", win_valid, 0);
        m_reuse = 1'b1;
        m_last  = a;
    endtask

    initial begin
        int unsigned guard;

        step();
        step();
        check("rst_req_ready", req_ready, 1);
        check("rst_win_valid", win_valid, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_pixels", pixels, 0);
        rst = 1'b1;
        step();

        // full fetch, spot-check individual pixels
        run_req(19'd0, 1'b0, 0);
        // slide
        exp_win_q.push_back('0);
        void'(exp_win_q.pop_back());
        run_req(19'd1, 1'b0, 0);
        check("slide_pixel1", pixels[9:0], 1);
        check("slide_pixel24", pixels[23*10 +: 10], 20);
        check("slide_pixel25", pixels[24*10 +: 10], 21);
        // non-consecutive with backpressure; flush held high in PRESENT is ignored
        run_req(19'd1000, 1'b0, 10);
        check("p1_1000", pixels[9:0], 232);
        check("p25_1000", pixels[24*10 +: 10], 252);
        run_req(19'd1001, 1'b0, 0);
        // flush in IDLE, then a consecutive request
        flush = 1'b1;
        step();
        flush   = 1'b0;
        m_reuse = 1'b0;
        run_req(19'd1002, 1'b0, 0);
        // flush together with a consecutive request
        run_req(19'd1003, 1'b1, 0);

        // reset during the 12th read of a fetch
        req_addr  = 19'd0;
        req_valid = 1'b1;
        reads     = 0;
        step();
        req_valid = 1'b0;
        guard = 0;
        while (reads < 12 && guard < 100) begin
            step();
            guard++;
        end
        check("reads_before_rst", reads, 12);
        rst = 1'b0;
        #1;
        check("mid_rst_mem_en", mem_en, 0);
        check("mid_rst_mem_addr", mem_addr, 0);
        check("mid_rst_win_valid", win_valid, 0);
        check("mid_rst_pixels", pixels, 0);
        check("mid_rst_req_ready", req_ready, 1);
        step();
        step();
        rst = 1'b1;
        exp_addr_q.delete();
        exp_win_q.delete();
        m_reuse = 1'b0;
        m_last  = '0;
        step();
        run_req(19'd1, 1'b0, 0);

        // address wrap-around, then a slide across the wrap
        run_req(19'd524287, 1'b0, 0);
        run_req(19'd0, 1'b0, 0);
        check("wrap_pixel1", pixels[9:0], 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // spot checks on the first full window, taken while it is presented
    initial begin
        int unsigned guard;
        guard = 0;
        while (win_valid !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("first_win_seen", win_valid, 1);
        check("pixel1", pixels[9:0], 0);
        check("pixel5", pixels[4*10 +: 10], 4);
        check("pixel6", pixels[5*10 +: 10], 4);
        check("pixel13", pixels[12*10 +: 10], 10);
        check("pixel25", pixels[24*10 +: 10], 20);
    end

endmodule
